// File: rtl/load_store_unit.sv
// Load/store unit: serialises one load/store request into big-endian byte accesses
// on a byte-wide memory port, with size/alignment checks and a per-byte timeout.
module load_store_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       Write_data,
  output logic [31:0]       Read_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  // Timeout fires when the counter would reach TIMEOUT_CYC on a stalled cycle.
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;          // index of byte currently on the port
  logic [1:0]        last_q, last_d;        // index of final byte (0, 1 or 3)
  logic [7:0]        tmo_q, tmo_d;
  logic              load_q, load_d;
  logic              sext_q, sext_d;
  logic [23:0]       wsh_q, wsh_d;          // store bytes still to be sent, MSB first
  logic [23:0]       rbuf_q, rbuf_d;        // load bytes received so far, shifted in
  logic [31:0]       read_data_q, read_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic              bad_req;
  logic [1:0]        req_last;
  logic [31:0]       store_word;
  logic [31:0]       load_word;
  logic [31:0]       load_ext;

  // Request decode: legality, byte count and left-justified store data.
  always_comb begin
    bad_req = (MemRead && MemWrite) || (size == 2'b11) ||
              (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    req_last   = 2'd3;
    store_word = Write_data;
    unique case (size)
      2'b00: begin
        req_last   = 2'd0;
        store_word = {Write_data[7:0], 24'h0};
      end
      2'b01: begin
        req_last   = 2'd1;
        store_word = {Write_data[15:0], 16'h0};
      end
      default: begin
        req_last   = 2'd3;
        store_word = Write_data;
      end
    endcase
  end

  // Assemble the load result including the byte arriving this cycle, then extend.
  always_comb begin
    load_word = {rbuf_q, mem_rdata};
    load_ext  = load_word;
    unique case (last_q)
      2'd0:    load_ext = {{24{sext_q & load_word[7]}}, load_word[7:0]};
      2'd1:    load_ext = {{16{sext_q & load_word[15]}}, load_word[15:0]};
      default: load_ext = load_word;
    endcase
  end

  // Next-state logic for the request FSM and all registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    tmo_d       = tmo_q;
    load_d      = load_q;
    sext_d      = sext_q;
    wsh_d       = wsh_q;
    rbuf_d      = rbuf_q;
    read_data_d = read_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        // A request with neither direction set is not a request at all.
        if (req_valid && (MemRead || MemWrite)) begin
          if (bad_req) begin
            state_d = StResp;
            err_d   = 1'b1;
          end else begin
            state_d     = StAccess;
            cnt_d       = 2'd0;
            last_d      = req_last;
            tmo_d       = 8'd0;
            load_d      = MemRead;
            sext_d      = sign_ext;
            rbuf_d      = 24'h0;
            wsh_d       = store_word[23:0];
            mem_wdata_d = store_word[31:24];
            mem_addr_d  = addr;
            mem_re_d    = MemRead;
            mem_we_d    = MemWrite;
          end
        end
      end
      StAccess: begin
        if (mem_ready) begin
          tmo_d  = 8'd0;
          rbuf_d = load_word[23:0];
          if (cnt_q == last_q) begin
            state_d  = StResp;
            done_d   = 1'b1;
            mem_re_d = 1'b0;
            mem_we_d = 1'b0;
            if (load_q) begin
              read_data_d = load_ext;
            end
          end else begin
            cnt_d       = cnt_q + 2'd1;
            mem_addr_d  = mem_addr_q + ADDR_W'(1);
            mem_wdata_d = wsh_q[23:16];
            wsh_d       = {wsh_q[15:0], 8'h0};
          end
        end else if (tmo_q == TmoLast) begin
          state_d  = StResp;
          err_d    = 1'b1;
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      last_q      <= 2'd0;
      tmo_q       <= 8'd0;
      load_q      <= 1'b0;
      sext_q      <= 1'b0;
      wsh_q       <= 24'h0;
      rbuf_q      <= 24'h0;
      read_data_q <= 32'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      tmo_q       <= tmo_d;
      load_q      <= load_d;
      sext_q      <= sext_d;
      wsh_q       <= wsh_d;
      rbuf_q      <= rbuf_d;
      read_data_q <= read_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign Read_data = read_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
